// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//
// MEM/WB pipeline boundary of the 5-stage RISC-V core.
//
// What it does:
//   - Aligns the raw data-memory word to the load size and offset.
//   - Sign- or zero-extends that value.
//   - Flags misaligned halfword and word loads.
//   - Registers everything into the writeback (W) stage.
//   - Keeps the retired-instruction counter.
//
// Every output is a flop, so no input reaches an output combinationally.
//
// Ports
//   clk           core clock; all state updates on the rising edge
//   rst           asynchronous, active-high reset
//   StallW        hold all W-stage registers
//   FlushW        insert a bubble into W (wins over StallW)
//   ValidM        M stage holds a real instruction
//   RegWriteM     instruction writes rd
//   ResultSrcM    00 ALU, 01 load, 10/11 PC+4
//   RdM           destination register
//   Funct3M       load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
//   ALUResultM    ALU result; also the load byte address
//   ReadDataM     raw aligned word from data memory
//   PcPlus4M      PC+4 of the M instruction
//   ValidW        W holds a real instruction
//   RegWriteW     qualified register-file write enable
//   ResultSrcW    registered ResultSrcM
//   RdW           registered RdM
//   ALUResultW    registered ALUResultM
//   ReadDataW     extended load data
//   PcPlus4W      registered PcPlus4M
//   LoadMisalignW W holds a misaligned load
//   InstRetW      count of retired instructions
//
// Pipeline control
//   A W-stage capture happens when (!StallW || FlushW).
//   - Flush capture: loads a bubble. The control and data fields go to zero,
//     and the counter is left alone.
//   - Normal capture: loads the M-stage fields.
//   - Stall without flush: freezes every W register, including the counter.
// -----------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StallW,
  input  logic             FlushW,
  input  logic             ValidM,
  input  logic             RegWriteM,
  input  logic [1:0]       ResultSrcM,
  input  logic [4:0]       RdM,
  input  logic [2:0]       Funct3M,
  input  logic [XLEN-1:0]  ALUResultM,
  input  logic [XLEN-1:0]  ReadDataM,
  input  logic [XLEN-1:0]  PcPlus4M,
  output logic             ValidW,
  output logic             RegWriteW,
  output logic [1:0]       ResultSrcW,
  output logic [4:0]       RdW,
  output logic [XLEN-1:0]  ALUResultW,
  output logic [XLEN-1:0]  ReadDataW,
  output logic [XLEN-1:0]  PcPlus4W,
  output logic             LoadMisalignW,
  output logic [CNT_W-1:0] InstRetW
);

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] RS_LOAD = 2'b01;

  // ---------------------------------------------------------------------------
  // Load extraction (M stage, combinational)
  // ---------------------------------------------------------------------------
  logic [1:0]      off;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_ext;
  logic            is_load;
  logic            misalign;

  assign off     = ALUResultM[1:0];
  assign is_load = ValidM && (ResultSrcM == RS_LOAD);

  // Byte lane picked by the full offset.
  always_comb begin
    byte_sel = ReadDataM[7:0];
    case (off)
      2'd0:    byte_sel = ReadDataM[7:0];
      2'd1:    byte_sel = ReadDataM[15:8];
      2'd2:    byte_sel = ReadDataM[23:16];
      default: byte_sel = ReadDataM[31:24];
    endcase
  end

  // Halfword lane: only off[1] selects.
  // A misaligned halfword (off[0]=1) still reads the lane that off[1] names.
  always_comb begin
    half_sel = off[1] ? ReadDataM[31:16] : ReadDataM[15:0];
  end

  always_comb begin
    load_ext = ReadDataM;
    case (Funct3M)
      F3_LB:   load_ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  load_ext = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   load_ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  load_ext = {{(XLEN-16){1'b0}}, half_sel};
      F3_LW:   load_ext = ReadDataM;
      // Reserved encodings pass the raw word through.
      default: load_ext = ReadDataM;
    endcase
  end

  // Misalignment is only meaningful for a real load.
  // Reserved funct3 values never flag.
  always_comb begin
    misalign = 1'b0;
    if (is_load) begin
      case (Funct3M)
        F3_LH, F3_LHU: misalign = off[0];
        F3_LW:         misalign = (off != 2'b00);
        default:       misalign = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Capture qualification
  // ---------------------------------------------------------------------------
  logic capture;
  logic reg_write_q;
  logic retire;

  assign capture = !StallW || FlushW;

  // Writes to x0 are suppressed, but the instruction still occupies W.
  assign reg_write_q = ValidM && RegWriteM && (RdM != 5'd0) && !misalign;

  // A misaligned load traps, so it does not retire.
  assign retire = ValidM && !misalign;

  // ---------------------------------------------------------------------------
  // W-stage registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ValidW        <= 1'b0;
      RegWriteW     <= 1'b0;
      ResultSrcW    <= 2'b00;
      RdW           <= 5'd0;
      ALUResultW    <= '0;
      ReadDataW     <= '0;
      PcPlus4W      <= '0;
      LoadMisalignW <= 1'b0;
      InstRetW      <= '0;
    end else if (capture) begin
      if (FlushW) begin
        ValidW        <= 1'b0;
        RegWriteW     <= 1'b0;
        ResultSrcW    <= 2'b00;
        RdW           <= 5'd0;
        ALUResultW    <= '0;
        ReadDataW     <= '0;
        PcPlus4W      <= '0;
        LoadMisalignW <= 1'b0;
      end else begin
        ValidW        <= ValidM;
        RegWriteW     <= reg_write_q;
        // ResultSrcM == 11 is carried through as-is.
        // The writeback mux treats it as PC+4.
        ResultSrcW    <= ResultSrcM;
        RdW           <= RdM;
        ALUResultW    <= ALUResultM;
        ReadDataW     <= load_ext;
        PcPlus4W      <= PcPlus4M;
        LoadMisalignW <= misalign;
        // Wraps modulo 2^CNT_W.
        if (retire) InstRetW <= InstRetW + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline boundary of the 5-stage RISC-V core.
- Takes memory-stage results plus the raw 32-bit data-memory word.
- Aligns and sign/zero-extends load data by funct3 and address offset, flags misaligned loads, and registers everything into the writeback stage.
- Outputs feed the writeback result multiplexer, the register-file write port and the hazard/forwarding unit. The block also keeps the 64-bit retired-instruction counter.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- StallW  in  1  hold all W-stage registers.
- FlushW  in  1  insert a bubble into W.
- ValidM  in  1  M stage holds a real instruction.
- RegWriteM  in  1  instruction writes rd.
- ResultSrcM  in  2  00 ALU, 01 load, 10/11 PC+4.
- RdM  in  5  destination register.
- Funct3M  in  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- ALUResultM  in  XLEN  ALU result; also the load byte address.
- ReadDataM  in  XLEN  raw aligned word from data memory.
- PcPlus4M  in  XLEN  PC+4 of the M instruction.
- ValidW  out  1  W holds a real instruction.
- RegWriteW  out  1  qualified register-file write enable.
- ResultSrcW  out  2  registered ResultSrcM.
- RdW  out  5  registered RdM.
- ALUResultW  out  XLEN  registered ALUResultM.
- ReadDataW  out  XLEN  extended load data.
- PcPlus4W  out  XLEN  registered PcPlus4M.
- LoadMisalignW  out  1  W holds a misaligned load.
- InstRetW  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (async assert, sync release): every output is 0, including InstRetW.
- Latency: one cycle from M inputs to W outputs. There is no combinational path from any input to any output.
- Load extraction (combinational, before the register). off = ALUResultM[1:0].
  - lb/lbu: byte ReadDataM[8*off+7 : 8*off].
  - lh/lhu: halfword ReadDataM[16*off[1]+15 : 16*off[1]].
  - lw: the full word.
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - Reserved funct3 (011, 110, 111): pass the raw word through; no flag.
- Misalign (only when ResultSrcM == 01 and ValidM): lh/lhu with off[0] = 1, or lw with off != 00.
  - The misaligned bytes are still extracted per the rule above.
- Capture load = !StallW || FlushW. Flush has priority over stall.
- On a flush capture: ValidW = 0, RegWriteW = 0, LoadMisalignW = 0, all data outputs 0.
- On a normal capture: all fields are registered.
  - RegWriteW = ValidM & RegWriteM & (RdM != 0) & !misalign.
  - LoadMisalignW = misalign.
- Stall without flush: every W register, including InstRetW, holds its value.
- x0 suppression: RdM == 0 never produces RegWriteW = 1, but ValidW and the data fields are still captured.
- InstRetW increments by 1 on each normal capture with ValidM = 1 and no misalign.
  - It does not increment on stall, on flush, or for a bubble/misaligned instruction.
  - It wraps modulo 2^CNT_W.
- ResultSrcM 11 is carried through unchanged; the downstream mux treats it as PC+4.
- Reset asserted mid-stall or mid-flush clears everything immediately. The first capture after release behaves as normal.

Test Plan:
- lb/lbu: ReadDataM = 0x80F1_7F82, ALUResultM = 0x1003.
  - Funct3M = 000 -> ReadDataW = 0xFFFF_FF80 one cycle later.
  - Funct3M = 100 -> ReadDataW = 0x0000_0080.
  - ValidW = 1, InstRetW steps by 1 on each load.
- lh/lhu: same word, addr 0x1002.
  - lh -> 0xFFFF_80F1; lhu -> 0x0000_80F1.
  - lw at 0x1000 -> 0x80F1_7F82.
- Misaligned lw at addr 0x1001, RegWriteM = 1, RdM = 5 -> LoadMisalignW = 1, RegWriteW = 0, InstRetW unchanged.
- Stall/flush priority:
  - StallW = 1 for 3 cycles while inputs change -> all outputs frozen.
  - StallW = 1 and FlushW = 1 together -> ValidW = 0, RegWriteW = 0 next cycle.
- x0 and passthrough: ALU op with RdM = 0, RegWriteM = 1, ALUResultM = 0x1234 -> ALUResultW = 0x1234, RegWriteW = 0, ValidW = 1.
- Reset and wrap:
  - Preload InstRetW near 0xFFFF_FFFF_FFFF_FFFF by force and retire 2 instructions -> 0x1.
  - Assert rst asynchronously mid-cycle -> all outputs 0 before the next edge.
